ddr_port_arbiter: RTL
=====================

Name: ddr_port_arbiter

Overview:
- Shares the single user command/data port of the DDR3 controller between N_PORTS requesters, for example the video write path, the video read path and the UART debug path.
- Sits between the requesters and the DDR controller user interface, in the core_clk domain.
- Grants one burst at a time with round-robin priority and routes that burst's write or read data beats.
- Issues no commands until ddr_init_done is high.

Parameters:
N_PORTS, 3, number of requesters (2..8)
ADDR_W, 28, command address width
LEN_W, 4, burst length field width; value = beats-1
DATA_W, 256, user data width

Ports:
core_clk  in  1  controller user clock
core_rst_n  in  1  asynchronous active-low reset
ddr_init_done  in  1  controller calibration complete
req  in  N_PORTS  per-port request; held until req_gnt
req_wr  in  N_PORTS  1=write, 0=read
req_addr  in  N_PORTS*ADDR_W  burst start address, flattened
req_len  in  N_PORTS*LEN_W  beats-1, flattened
req_gnt  out  N_PORTS  1-cycle pulse when the port's command is accepted
req_done  out  N_PORTS  1-cycle pulse after the port's last data beat
wr_data  in  N_PORTS*DATA_W  per-port write data
wr_valid  in  N_PORTS  per-port write data valid
wr_ready  out  N_PORTS  per-port write data ready
rd_data  out  DATA_W  read data, broadcast to all ports
rd_valid  out  N_PORTS  per-port read data valid
len_err  out  1  sticky flag: read rlast disagreed with beat count
cmd_valid  out  1  command to controller
cmd_ready  in  1  controller accepts command
cmd_wr  out  1  command direction
cmd_addr  out  ADDR_W  command address
cmd_len  out  LEN_W  command length
wdata  out  DATA_W  write data to controller
wvalid  out  1  write data valid
wready  in  1  controller write ready
wlast  out  1  last write beat
rdata  in  DATA_W  read data from controller
rvalid  in  1  read data valid
rlast  in  1  last read beat

Behaviour:
- Reset (async, core_rst_n=0): state=IDLE, rr_ptr=0, beat count=0, len_err=0. All outputs low: cmd_*, wvalid, wlast, req_gnt, req_done, wr_ready, rd_valid.
- FSM states: IDLE, CMD, WDATA, RDATA.
- IDLE:
  - Arbitrates only when ddr_init_done=1 and |req.
  - Winner is the first set req bit at or above rr_ptr, wrapping modulo N_PORTS.
  - Next cycle: state=CMD. cmd_valid=1. cmd_wr, cmd_addr and cmd_len are registered from the winner. Latency from req to cmd_valid is 1 cycle.
- CMD:
  - cmd_* held stable until cmd_valid && cmd_ready.
  - On that cycle: req_gnt[winner] pulses, rr_ptr = winner+1 mod N_PORTS, beat count cleared.
  - Next state is WDATA if cmd_wr=1, else RDATA.
- WDATA:
  - Combinational pass-through: wdata=wr_data[winner], wvalid=wr_valid[winner], wr_ready[winner]=wready. Other ports' wr_ready=0.
  - wlast = wvalid && (count==cmd_len).
  - A beat is wvalid && wready; each beat increments count.
  - On the last beat: req_done[winner] pulses on the next cycle and state returns to IDLE.
- RDATA:
  - rd_data=rdata. rd_valid[winner]=rvalid; other ports' rd_valid=0.
  - Each rvalid increments count. The transaction ends on the beat with count==cmd_len.
  - If rlast is not equal to (count==cmd_len) on any rvalid beat, len_err is set and stays set until reset. Termination still follows the count.
  - req_done pulses on the next cycle; state returns to IDLE.
- Back-to-back transactions: a new arbitration happens in the IDLE cycle after req_done. Minimum gap is 1 idle cycle.
- Requester rule: a requester must keep req, req_wr, req_addr and req_len stable until its req_gnt. A req deasserted before grant is simply not considered.
- Write data: a requester may present write data before its grant; wr_ready stays 0 until WDATA.
- ddr_init_done falling mid-transaction: the current burst completes normally; no new grant until it returns high.
- cmd_len=0: single beat, so wlast is set on the first beat.
- Maximum cmd_len (all ones): 2^LEN_W beats; the counter is LEN_W bits wide and needs no wrap.
- Simultaneous requests: the round-robin scheme guarantees each requesting port is granted within N_PORTS transactions.

Decomposition:
- Shared package ddr_arb_pkg holds:
  - state encoding constants (ST_IDLE, ST_CMD, ST_WDATA, ST_RDATA);
  - the default ADDR_W, LEN_W and DATA_W values.
- One sub-module, rr_arbiter: combinational round-robin pick from req plus rr_ptr, producing a one-hot grant and a binary index. It is reusable for other shared ports.

Test Plan:
1. ddr_init_done=0, req=3'b111 for 50 cycles -> cmd_valid stays 0. Raise ddr_init_done -> cmd_valid next cycle for port 0.
2. Port 1 write: addr=0x100, len=3, wready always 1 -> exactly 4 wdata beats, wlast on the 4th, req_gnt[1] then req_done[1] single pulses.
3. All three ports request continuously with len=0 reads -> grant order 0,1,2,0,1,2. rd_valid is routed only to the granted port.
4. Port 2 read, len=7, rlast asserted on beat 5 -> len_err=1 and sticky; transaction still ends after 8 rvalid beats.
5. cmd_ready held 0 for 10 cycles while port 0 requests -> cmd_addr and cmd_len stable throughout. Port 1 raising req meanwhile does not change the command.
6. core_rst_n pulsed low mid-WDATA (beat 2 of 4) -> outputs zero immediately. After release: IDLE, rr_ptr=0, a fresh arbitration, len_err=0.

Source files
------------

// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared state encoding and default widths for the DDR port arbiter
package ddr_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WDATA,
    ST_RDATA
  } state_t;
  localparam int DEF_ADDR_W = 28;
  localparam int DEF_LEN_W  = 4;
  localparam int DEF_DATA_W = 256;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  // scan from the furthest candidate back towards ptr so the nearest requester wins
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + i) % N] = 1'b1;
        idx = IW'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: round-robin sharing of the DDR controller user port between requesters
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int N_PORTS = 3,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                        core_clk,
  input  logic                        core_rst_n,
  input  logic                        ddr_init_done,
  input  logic [N_PORTS-1:0]          req,
  input  logic [N_PORTS-1:0]          req_wr,
  input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
  input  logic [N_PORTS*LEN_W-1:0]    req_len,
  output logic [N_PORTS-1:0]          req_gnt,
  output logic [N_PORTS-1:0]          req_done,
  input  logic [N_PORTS*DATA_W-1:0]   wr_data,
  input  logic [N_PORTS-1:0]          wr_valid,
  output logic [N_PORTS-1:0]          wr_ready,
  output logic [DATA_W-1:0]           rd_data,
  output logic [N_PORTS-1:0]          rd_valid,
  output logic                        len_err,
  output logic                        cmd_valid,
  input  logic                        cmd_ready,
  output logic                        cmd_wr,
  output logic [ADDR_W-1:0]           cmd_addr,
  output logic [LEN_W-1:0]            cmd_len,
  output logic [DATA_W-1:0]           wdata,
  output logic                        wvalid,
  input  logic                        wready,
  output logic                        wlast,
  input  logic [DATA_W-1:0]           rdata,
  input  logic                        rvalid,
  input  logic                        rlast
);
  localparam int IW = $clog2(N_PORTS);
  localparam logic [IW-1:0] LAST_P = IW'(N_PORTS - 1);
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, win, pick_idx;
  logic [N_PORTS-1:0] pick_gnt;
  logic [LEN_W-1:0] cnt;
  logic arb, accept, wbeat, rbeat, last;
  rr_arbiter #(.N(N_PORTS)) u_rr (
    .req(req),
    .ptr(rr_ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );
  assign arb       = ddr_init_done && |pick_gnt;
  assign last      = cnt == cmd_len;
  assign accept    = state == ST_CMD && cmd_ready;
  assign wbeat     = state == ST_WDATA && wr_valid[win] && wready;
  assign rbeat     = state == ST_RDATA && rvalid;
  assign cmd_valid = state == ST_CMD;
  assign rd_data   = rdata;
  // state register
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) state <= ST_IDLE;
    else state <= state_nx;
  end
  // next state plus the per-state routing of grant and data handshakes to the winner
  always_comb begin
    state_nx = state;
    req_gnt  = '0;
    wr_ready = '0;
    rd_valid = '0;
    wdata    = '0;
    wvalid   = 1'b0;
    wlast    = 1'b0;
    case (state)
      ST_IDLE: state_nx = arb ? ST_CMD : ST_IDLE;
      ST_CMD: begin
        req_gnt[win] = cmd_ready;
        state_nx = cmd_ready ? (cmd_wr ? ST_WDATA : ST_RDATA) : ST_CMD;
      end
      ST_WDATA: begin
        wdata         = wr_data[win*DATA_W +: DATA_W];
        wvalid        = wr_valid[win];
        wr_ready[win] = wready;
        wlast         = wr_valid[win] && last;
        state_nx      = (wbeat && last) ? ST_IDLE : ST_WDATA;
      end
      ST_RDATA: begin
        rd_valid[win] = rvalid;
        state_nx      = (rbeat && last) ? ST_IDLE : ST_RDATA;
      end
      default: state_nx = ST_IDLE;
    endcase
  end
  // command capture, round-robin pointer, beat counting, length check and done pulse
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      rr_ptr   <= '0;
      win      <= '0;
      cnt      <= '0;
      len_err  <= 1'b0;
      cmd_wr   <= 1'b0;
      cmd_addr <= '0;
      cmd_len  <= '0;
      req_done <= '0;
    end else begin
      req_done <= '0;
      if (state == ST_IDLE && arb) begin
        win      <= pick_idx;
        cmd_wr   <= req_wr[pick_idx];
        cmd_addr <= req_addr[pick_idx*ADDR_W +: ADDR_W];
        cmd_len  <= req_len[pick_idx*LEN_W +: LEN_W];
      end
      if (accept) begin
        rr_ptr <= (win == LAST_P) ? '0 : win + 1'b1;
        cnt    <= '0;
      end
      if (wbeat || rbeat) cnt <= cnt + 1'b1;
      if (rbeat && (rlast != last)) len_err <= 1'b1;
      if ((wbeat || rbeat) && last) req_done[win] <= 1'b1;
    end
  end
endmodule
